// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, hands fetched instruction to IF/ID.
// Latency: FETCH->WAIT->OUT (3 cycles per instruction at zero-wait); holds output while enable=0.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic        f_valid
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        squash, squash_nxt;
   logic [31:0] instr_nxt, fpc_nxt;
   logic        valid_nxt;
   logic [31:0] target;

   assign target    = {redirect_pc[31:2], 2'b00};
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         squash  <= 1'b0;
         f_valid <= 1'b0;
         f_instr <= NOP_INSTR;
         f_pc    <= RESET_PC;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         squash  <= squash_nxt;
         f_valid <= valid_nxt;
         f_instr <= instr_nxt;
         f_pc    <= fpc_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      squash_nxt = squash;
      valid_nxt  = f_valid;
      instr_nxt  = f_instr;
      fpc_nxt    = f_pc;
      imem_req   = 1'b0;

      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (redirect) pc_nxt = target;
            if (imem_gnt) begin
               state_nxt = S_WAIT;
               // Granted address is now stale; drop its response when it returns.
               if (redirect) squash_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (squash || redirect) begin
                  squash_nxt = 1'b0;
                  if (redirect) pc_nxt = target;
                  state_nxt = S_FETCH;
               end else begin
                  instr_nxt = imem_rdata;
                  fpc_nxt   = pc;
                  valid_nxt = 1'b1;
                  state_nxt = S_OUT;
               end
            end else if (redirect) begin
               pc_nxt     = target;
               squash_nxt = 1'b1;
            end
         end
         S_OUT: begin
            if (redirect) begin
               valid_nxt = 1'b0;
               instr_nxt = NOP_INSTR;
               pc_nxt    = target;
               state_nxt = S_FETCH;
            end else if (enable) begin
               valid_nxt = 1'b0;
               instr_nxt = NOP_INSTR;
               pc_nxt    = pc + 32'd4;
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: instance 0 uses RESET_PC=0, instance 1 RESET_PC=0xFFFF_FFFC.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        imem_req    [2];
   logic [31:0] imem_addr   [2];
   logic        imem_gnt    [2];
   logic        imem_rvalid [2];
   logic [31:0] imem_rdata  [2];
   logic [31:0] f_instr     [2];
   logic [31:0] f_pc        [2];
   logic        f_valid     [2];

   // memory model state
   logic        gnt_en;
   logic        mdl_clr;
   logic [1:0]  lat;
   logic        pend  [2];
   logic [1:0]  cnt   [2];
   logic [31:0] paddr [2];

   int n_cmp;
   int n_err;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_gnt(imem_gnt[0]),
      .imem_rvalid(imem_rvalid[0]), .imem_rdata(imem_rdata[0]),
      .f_instr(f_instr[0]), .f_pc(f_pc[0]), .f_valid(f_valid[0])
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_gnt(imem_gnt[1]),
      .imem_rvalid(imem_rvalid[1]), .imem_rdata(imem_rdata[1]),
      .f_instr(f_instr[1]), .f_pc(f_pc[1]), .f_valid(f_valid[1])
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_rd = 32'h0000_00A1;
         32'h0000_0004: mem_rd = 32'h0000_0049;
         32'h0000_0008: mem_rd = 32'h0000_05A5;
         32'h0000_0100: mem_rd = 32'h1234_0013;
         32'h0000_0200: mem_rd = 32'h0BAD_0093;
         default:       mem_rd = a ^ 32'hC0DE_0000;
      endcase
   endfunction

   // One outstanding request per instance; no grant while a response is pending.
   for (genvar g = 0; g < 2; g++) begin : g_mem
      assign imem_gnt[g]    = gnt_en && !pend[g];
      assign imem_rvalid[g] = pend[g] && (cnt[g] == 2'd0);
      assign imem_rdata[g]  = mem_rd(paddr[g]);
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mdl_clr) begin
            pend[i]  <= 1'b0;
            cnt[i]   <= 2'd0;
            paddr[i] <= 32'd0;
         end else if (pend[i]) begin
            if (cnt[i] == 2'd0) pend[i] <= 1'b0;
            else                cnt[i]  <= cnt[i] - 2'd1;
         end else if (imem_req[i] && imem_gnt[i]) begin
            pend[i]  <= 1'b1;
            cnt[i]   <= lat;
            paddr[i] <= imem_addr[i];
         end
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      reset       = 1'b0;
      enable      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      gnt_en      = 1'b0;
      lat         = 2'd0;
      mdl_clr     = 1'b1;

      // 1. reset for two edges
      @(negedge clk);
      tick();
      tick();
      mdl_clr = 1'b0;
      chk("rst_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("rst_instr", f_instr[0], 32'h0000_0013);
      chk("rst_pc",    f_pc[0],    32'h0000_0000);
      reset = 1'b1;
      chk("rst_req",   {31'd0, imem_req[0]}, 32'd1);
      chk("rst_addr",  imem_addr[0], 32'h0000_0000);

      // 2/3. first fetch, then stall in OUT
      gnt_en = 1'b1;
      tick();
      chk("wait_valid", {31'd0, f_valid[0]}, 32'd0);
      tick();
      chk("out0_valid", {31'd0, f_valid[0]}, 32'd1);
      chk("out0_pc",    f_pc[0],    32'h0000_0000);
      chk("out0_instr", f_instr[0], 32'h0000_00A1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", {31'd0, f_valid[0]}, 32'd1);
         chk("stall_pc",    f_pc[0],    32'h0000_0000);
         chk("stall_instr", f_instr[0], 32'h0000_00A1);
         chk("stall_req",   {31'd0, imem_req[0]}, 32'd0);
      end
      enable = 1'b1;
      tick();
      chk("cons_addr",  imem_addr[0], 32'h0000_0004);
      chk("cons_req",   {31'd0, imem_req[0]}, 32'd1);
      chk("cons_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("cons_instr", f_instr[0], 32'h0000_0013);
      chk("cons_fpc",   f_pc[0],    32'h0000_0000);
      tick();
      chk("s1_wait_valid", {31'd0, f_valid[0]}, 32'd0);
      tick();
      chk("out4_valid", {31'd0, f_valid[0]}, 32'd1);
      chk("out4_pc",    f_pc[0],    32'h0000_0004);
      chk("out4_instr", f_instr[0], 32'h0000_0049);
      tick();
      chk("f8_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("f8_addr",  imem_addr[0], 32'h0000_0008);
      tick();
      chk("w8_valid", {31'd0, f_valid[0]}, 32'd0);
      tick();
      chk("out8_valid", {31'd0, f_valid[0]}, 32'd1);
      chk("out8_pc",    f_pc[0],    32'h0000_0008);
      chk("out8_instr", f_instr[0], 32'h0000_05A5);

      // 4. redirect in WAIT one cycle before rvalid
      lat = 2'd1;
      tick();
      chk("fC_addr", imem_addr[0], 32'h0000_000C);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      chk("rdw_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("rdw_req",   {31'd0, imem_req[0]}, 32'd0);
      tick();
      chk("rdw_drop_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("rdw_req2",       {31'd0, imem_req[0]}, 32'd1);
      chk("rdw_addr",       imem_addr[0], 32'h0000_0100);
      lat = 2'd0;
      tick();
      tick();
      chk("o100_valid", {31'd0, f_valid[0]}, 32'd1);
      chk("o100_pc",    f_pc[0],    32'h0000_0100);
      chk("o100_instr", f_instr[0], 32'h1234_0013);

      // 5. redirect in OUT with enable=1, unaligned target
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      tick();
      redirect = 1'b0;
      chk("rdo_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("rdo_instr", f_instr[0],   32'h0000_0013);
      chk("rdo_addr",  imem_addr[0], 32'h0000_0200);
      chk("rdo_fpc",   f_pc[0],      32'h0000_0100);
      tick();
      tick();
      chk("o200_pc",    f_pc[0],    32'h0000_0200);
      chk("o200_instr", f_instr[0], 32'h0BAD_0093);

      // 6a. PC wrap on the instance reset to 0xFFFF_FFFC
      reset  = 1'b0;
      gnt_en = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      chk("wrap_rst_addr", imem_addr[1], 32'hFFFF_FFFC);
      chk("wrap_rst_fpc",  f_pc[1],      32'hFFFF_FFFC);
      gnt_en = 1'b1;
      tick();
      tick();
      chk("wrap_out_valid", {31'd0, f_valid[1]}, 32'd1);
      chk("wrap_out_pc",    f_pc[1],    32'hFFFF_FFFC);
      chk("wrap_out_instr", f_instr[1], 32'h3F21_FFFC);
      tick();
      chk("wrap_addr", imem_addr[1], 32'h0000_0000);

      // 6b. reset while waiting; the late response must be ignored
      chk("rw_pre_addr", imem_addr[0], 32'h0000_0004);
      lat = 2'd1;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("rw_valid", {31'd0, f_valid[0]}, 32'd0);
      chk("rw_instr", f_instr[0], 32'h0000_0013);
      chk("rw_req",   {31'd0, imem_req[0]}, 32'd1);
      chk("rw_addr",  imem_addr[0], 32'h0000_0000);
      lat = 2'd0;
      tick();
      tick();
      chk("rw_out_valid", {31'd0, f_valid[0]}, 32'd1);
      chk("rw_out_pc",    f_pc[0],    32'h0000_0000);
      chk("rw_out_instr", f_instr[0], 32'h0000_00A1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end fetch stage: owns the PC and issues requests on the instruction-memory request/grant/response interface. It presents the fetched instruction and its PC (f_instr, f_pc, f_valid) to the producer side of if_id_register. Fetch holds while the hazard unit deasserts enable, and squashes in-flight fetches on a branch/jump redirect from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, instruction driven on f_instr whenever f_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block
enable  input  1  from hazard unit; 1 = IF/ID register captures f_* this edge
redirect  input  1  branch/jump taken; overrides sequential PC
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00)
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction
f_instr  output  32  instruction to IF/ID
f_pc  output  32  PC of f_instr
f_valid  output  1  f_instr/f_pc hold a real instruction

Behaviour:
- Reset (reset=0 at an edge): pc<=RESET_PC, state<=FETCH, squash<=0, f_valid<=0, f_instr<=NOP_INSTR, f_pc<=RESET_PC. Reset overrides all other inputs.
- imem_addr = pc at all times. imem_req = 1 only in FETCH (combinational from state).
- Memory protocol: imem_rvalid arrives at least 1 cycle after the granting edge. Exactly one response per grant. imem_rvalid outside WAIT is ignored.
- FETCH:
  - gnt=1, no redirect: ->WAIT.
  - gnt=1 with redirect: pc<=redirect_pc, squash<=1, ->WAIT.
  - gnt=0 with redirect: pc<=redirect_pc, stay FETCH. The address may change while ungranted.
- WAIT:
  - rvalid=1 and (squash or redirect): discard rdata, squash<=0, pc<=redirect_pc if redirect, ->FETCH.
  - rvalid=1 otherwise: f_instr<=imem_rdata, f_pc<=pc, f_valid<=1, ->OUT.
  - rvalid=0 with redirect: pc<=redirect_pc, squash<=1, stay WAIT.
- OUT (f_valid=1):
  - redirect (priority over enable): f_valid<=0, f_instr<=NOP_INSTR, pc<=redirect_pc, ->FETCH.
  - else enable=1: the instruction is consumed; f_valid<=0, f_instr<=NOP_INSTR, pc<=pc+4, ->FETCH.
  - else (enable=0): all outputs held unchanged, no request issued.
- pc+4 is modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Throughput with zero-wait memory (gnt in FETCH, rvalid next cycle): one instruction per 3 cycles (FETCH, WAIT, OUT).
- f_pc is not updated when f_valid drops; only f_instr returns to NOP_INSTR.
- Reset during WAIT: ->FETCH at RESET_PC. The stale rvalid that follows arrives in FETCH and is ignored. The memory model must not grant it as a new request.

Test Plan:
1. Reset: hold reset=0 for 2 edges then release -> f_valid=0, f_instr=0x13, f_pc=0. First cycle after release: imem_req=1, imem_addr=0.
2. Streaming: imem_gnt=1, rvalid 1 cycle after grant, mem[0]=0xA1, mem[4]=0x49, enable=1 -> f_valid pulses with (f_pc=0, f_instr=0xA1) then (f_pc=4, f_instr=0x49). Pulses are 3 cycles apart.
3. Stall: enable=0 while in OUT holding (f_pc=0, 0xA1) for 5 cycles -> outputs stable, imem_req=0 throughout. Raise enable=1 -> next imem_addr=4.
4. Redirect in WAIT: redirect=1, redirect_pc=0x100 one cycle before rvalid -> rdata dropped, f_valid stays 0, next request imem_addr=0x100.
5. Redirect in OUT together with enable=1, redirect_pc=0x203 -> f_valid=0, f_instr=0x13, next imem_addr=0x200.
6. Wrap/reset: RESET_PC=0xFFFF_FFFC, consume one instruction -> next imem_addr=0. Separately, assert reset in WAIT -> stale rvalid ignored, request restarts at RESET_PC.
